dmem_ctrl: RTL
==============

# dmem_ctrl

Memory-stage responder for the 5-stage MIPS pipeline. It services load and store requests issued by the datapath's M stage against a fixed-latency, fully pipelined word SRAM. It steers byte and halfword lanes, sign- or zero-extends load data, flags misaligned addresses, and holds the pipeline through read latency with `stall_m`. It returns load data to the pipeline with a one-cycle valid pulse.

## Interface
- `RD_LAT`, default 1: SRAM read latency in cycles; legal range 1..4.
- `clka` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: M-stage memory request present; held stable while `stall_m`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_sign` in 1: load extension; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `flush_m` in 1: abort the outstanding load (exception or flush).
- `stall_m` out 1: freeze F/D/E/M; high while a load is in flight.
- `rdata` out 32: extended load data; valid only when `rdata_valid`=1.
- `rdata_valid` out 1: one-cycle pulse with the load result.
- `adel` out 1: load address error (combinational, request cycle).
- `ades` out 1: store address error (combinational, request cycle).
- `sram_en` out 1: SRAM access strobe.
- `sram_wen` out 4: per-byte write enables.
- `sram_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `sram_wdata` out 32: lane-replicated store data.
- `sram_rdata` in 32: SRAM read data, valid RD_LAT cycles after `sram_en` with `sram_wen`=0.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **Misalignment**
  - Misaligned means half with `addr[0]`≠0, or word with `addr[1:0]`≠0.
  - A misaligned access raises `adel` (load) or `ades` (store) in the same cycle.
  - No SRAM strobe, no stall, state stays IDLE.
- **Store** (IDLE, aligned)
  - `sram_en`=1 combinationally. No stall; the store is posted.
  - `sram_wen`:
    - byte: `4'b0001<<addr[1:0]`
    - half: `addr[1]` ? 1100 : 0011
    - word: 1111
  - `sram_wdata`: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- **Load** (IDLE, aligned)
  - `sram_en`=1, `sram_wen`=0, `stall_m`=1.
  - Register `addr[1:0]`, size, and sign; load counter with RD_LAT−1; go to WAIT.
- **WAIT**
  - `stall_m`=1, counter decrements.
  - When the counter is 0: capture `sram_rdata` into the data register and go to DONE.
  - RD_LAT=1 means exactly one WAIT cycle.
- **DONE**
  - `stall_m`=0, `rdata_valid`=1, `rdata` = extracted and extended register value; go to IDLE.
  - Extraction:
    - byte lane `addr[1:0]`, bits 7:0 extended from bit 7 per `req_sign`
    - half lane `addr[1]`, extended from bit 15
    - word unchanged
- **Flush**
  - `flush_m`=1 in WAIT or DONE: go to IDLE next cycle, `stall_m`=0 and `rdata_valid`=0 that cycle.
  - Late SRAM data is ignored. In-order fixed latency means a following request cannot receive it.
  - `flush_m` in IDLE has no effect; a same-cycle request is dropped (no strobe).
- **Back-to-back**: a request seen in the cycle after DONE is a new request.

## Timing
- Reset values (rst=0 at an edge): state IDLE, counter 0, data register 0. All registered outputs are 0.
  - `stall_m`=0, `rdata_valid`=0, `rdata`=0.
- Combinational SRAM outputs are 0 while `rst`=0.
- Reset mid-load aborts with no `rdata_valid`.
- Load occupancy: RD_LAT+2 cycles, with `stall_m` high for RD_LAT+1 cycles starting in the request cycle.
- Store occupancy: 1 cycle.
- Maximum throughput: one store per cycle, or one load per RD_LAT+2 cycles.
- `rdata` is driven from the register, so it has no combinational path from `sram_rdata`.
- `adel`/`ades` are combinational from `req_*`; they are never asserted outside IDLE.

## Structure
- Package `dmem_pkg` holds:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - the state enum `dmem_state_t`
  - `RD_LAT_MAX`=4
- Sub-module `dmem_lane_align` (combinational): store lane steering with `wen` generation, and load extraction with extension. Instantiated once.
- The top level holds the FSM, latency counter, captured request fields, and data register.

## Test plan
- **Word load, RD_LAT=2**: SRAM[0x100]=0xDEADBEEF, load word 0x100.
  - `stall_m` high 3 cycles; `rdata_valid` in cycle 3 with 0xDEADBEEF.
- **Byte loads** of word 0x80C0FF7F at `addr[1:0]`=0..3:
  - signed: 0x0000007F, 0xFFFFFFFF, 0xFFFFFFC0, 0xFFFFFF80
  - unsigned: 0x7F, 0xFF, 0xC0, 0x80
- **Stores** to 0x202:
  - `sb` 0xAB: `wen`=0100, `wdata`=0xABABABAB
  - `sh` 0x1234: `wen`=1100, `wdata`=0x12341234
  - `stall_m` stays 0 for both
- **Misaligned**:
  - load half at 0x101: `adel`=1, `sram_en`=0, `stall_m`=0
  - store word at 0x102: `ades`=1, `wen`=0000
- **Flush**: `flush_m` asserted in the first WAIT cycle of a RD_LAT=3 load.
  - No `rdata_valid`; IDLE next cycle.
  - An immediately following load of 0x300 returns SRAM[0x300], not the stale data.
- **Reset**: `rst`=0 mid-WAIT.
  - All outputs 0, state IDLE, no `rdata_valid`.
  - A load after reset completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the M-stage data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction plus extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wen,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    st_wen       = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_wen       = 4'b0001 << st_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_wen       = st_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_lo, 3'b000} +: 8];
    ld_half = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage load/store responder for a fixed-latency, fully pipelined word SRAM.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush_m,
  output logic        stall_m,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lo_q, lo_d;
  logic [1:0]       size_q, size_d;
  logic             sign_q, sign_d;
  logic [31:0]      data_q, data_d;

  logic        accept, misaligned, ld_go, st_go;
  logic [3:0]  st_wen;
  logic [31:0] st_wdata_rep, ld_data;

  // A flush in the request cycle drops the request entirely, error flags included.
  assign accept     = rst && (state_q == IDLE) && req_valid && !flush_m;
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  assign ld_go      = accept && !req_we && !misaligned;
  assign st_go      = accept &&  req_we && !misaligned;

  dmem_lane_align u_align (
    .st_size      (req_size),
    .st_lo        (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_wen       (st_wen),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_q),
    .ld_lo        (lo_q),
    .ld_sign      (sign_q),
    .ld_word      (data_q),
    .ld_data      (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    size_d  = size_q;
    sign_d  = sign_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (ld_go) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
          lo_d    = req_addr[1:0];
          size_d  = req_size;
          sign_d  = req_sign;
        end
      end
      WAIT: begin
        if (flush_m) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          data_d  = sram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clka) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
    end
  end

  assign stall_m     = ld_go || (rst && (state_q == WAIT) && !flush_m);
  assign rdata_valid = rst && (state_q == DONE) && !flush_m;
  assign rdata       = rst ? ld_data : '0;
  assign adel        = accept && !req_we && misaligned;
  assign ades        = accept &&  req_we && misaligned;

  // SRAM-side outputs stay quiet unless an access is actually issued.
  assign sram_en    = ld_go || st_go;
  assign sram_wen   = st_go ? st_wen : 4'b0000;
  assign sram_addr  = sram_en ? {req_addr[31:2], 2'b00} : '0;
  assign sram_wdata = st_go ? st_wdata_rep : '0;

endmodule
